// File: rtl/mmss_upcounter.sv
// Up-counting MM:SS stopwatch core: seconds 0..59 carry into minutes 0..MAX_MIN,
// with start/stop, clear, lap-hold display and saturation at MAX_MIN:59.
module mmss_upcounter #(
    parameter int MAX_MIN = 99
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_start_stop,
    input  logic       i_clear,
    input  logic       i_lap,
    output logic [5:0] o_sec_q,
    output logic [6:0] o_min_q,
    output logic       o_running,
    output logic       o_lap_active,
    output logic       o_sec_carry,
    output logic       o_full
);

    localparam logic [6:0] MAX_M = 7'(MAX_MIN);

    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

    state_t     r_state;
    logic [5:0] r_cnt_sec;
    logic [6:0] r_cnt_min;
    logic [5:0] r_disp_sec;
    logic [6:0] r_disp_min;
    logic       r_lap_active;
    logic       r_sec_carry;
    logic       r_full;

    logic       w_cnt_en;
    logic [5:0] w_sec_nxt;
    logic [6:0] w_min_nxt;
    logic       w_carry;
    logic       w_sat;
    logic       w_lap_nxt;

    // A start_stop in the same cycle as a tick always swallows the tick.
    assign w_cnt_en  = (r_state == RUNNING) && i_tick && !i_start_stop;
    assign w_lap_nxt = i_lap ? !r_lap_active : r_lap_active;

    always_comb begin
        w_sec_nxt = r_cnt_sec;
        w_min_nxt = r_cnt_min;
        w_carry   = 1'b0;
        w_sat     = 1'b0;
        if (w_cnt_en) begin
            if (r_cnt_sec < 6'd59) begin
                w_sec_nxt = r_cnt_sec + 6'd1;
                w_sat     = (r_cnt_min == MAX_M) && (r_cnt_sec == 6'd58);
            end else if (r_cnt_min < MAX_M) begin
                w_sec_nxt = 6'd0;
                w_min_nxt = r_cnt_min + 7'd1;
                w_carry   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= STOPPED;
            r_cnt_sec    <= '0;
            r_cnt_min    <= '0;
            r_disp_sec   <= '0;
            r_disp_min   <= '0;
            r_lap_active <= 1'b0;
            r_sec_carry  <= 1'b0;
            r_full       <= 1'b0;
        end else if (i_clear) begin
            r_state      <= STOPPED;
            r_cnt_sec    <= '0;
            r_cnt_min    <= '0;
            r_disp_sec   <= '0;
            r_disp_min   <= '0;
            r_lap_active <= 1'b0;
            r_sec_carry  <= 1'b0;
            r_full       <= 1'b0;
        end else begin
            r_cnt_sec    <= w_sec_nxt;
            r_cnt_min    <= w_min_nxt;
            r_sec_carry  <= w_carry;
            r_lap_active <= w_lap_nxt;

            if (w_sat) begin
                r_full  <= 1'b1;
                r_state <= STOPPED;
            end else if (i_start_stop) begin
                if (r_state == RUNNING)
                    r_state <= STOPPED;
                else if (!r_full)
                    r_state <= RUNNING;
            end

            // Entering hold freezes the pre-tick count; otherwise track the new count.
            if (i_lap && !r_lap_active) begin
                r_disp_sec <= r_cnt_sec;
                r_disp_min <= r_cnt_min;
            end else if (!w_lap_nxt) begin
                r_disp_sec <= w_sec_nxt;
                r_disp_min <= w_min_nxt;
            end
        end
    end

    assign o_sec_q      = r_disp_sec;
    assign o_min_q      = r_disp_min;
    assign o_running    = (r_state == RUNNING);
    assign o_lap_active = r_lap_active;
    assign o_sec_carry  = r_sec_carry;
    assign o_full       = r_full;

endmodule

// File: tb/tb_mmss_upcounter.sv
// Bench for mmss_upcounter: two instances (MAX_MIN=99 and MAX_MIN=2) share stimulus
// and are compared every cycle against a total-seconds reference model.
module tb_mmss_upcounter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0, ss = 1'b0, clr = 1'b0, lap = 1'b0;

    logic [5:0] sec_q [2];
    logic [6:0] min_q [2];
    logic       run   [2];
    logic       lapa  [2];
    logic       carry [2];
    logic       full  [2];

    always #5 clk = ~clk;

    mmss_upcounter #(.MAX_MIN(99)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_start_stop(ss),
        .i_clear(clr), .i_lap(lap), .o_sec_q(sec_q[0]), .o_min_q(min_q[0]),
        .o_running(run[0]), .o_lap_active(lapa[0]), .o_sec_carry(carry[0]),
        .o_full(full[0]));

    mmss_upcounter #(.MAX_MIN(2)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_start_stop(ss),
        .i_clear(clr), .i_lap(lap), .o_sec_q(sec_q[1]), .o_min_q(min_q[1]),
        .o_running(run[1]), .o_lap_active(lapa[1]), .o_sec_carry(carry[1]),
        .o_full(full[1]));

    // Reference model: elapsed time as a single seconds total.
    typedef struct {
        int total;
        int disp;
        bit run;
        bit full;
        bit lap;
        bit carry;
    } mdl_t;

    mdl_t m [2];
    int checks = 0;
    int failures = 0;

    function automatic int maxm(int k);
        return (k == 0) ? 99 : 2;
    endfunction

    function automatic mdl_t mzero();
        mdl_t z;
        z.total = 0; z.disp = 0; z.run = 0; z.full = 0; z.lap = 0; z.carry = 0;
        return z;
    endfunction

    function automatic mdl_t mstep(mdl_t s, int mx, bit t, bit st, bit c, bit l);
        mdl_t n;
        int lim;
        lim = mx * 60 + 59;
        if (c) return mzero();
        n = s;
        n.carry = 0;
        if (st) begin
            if (s.run) n.run = 0;
            else if (!s.full) n.run = 1;
        end
        if (s.run && t && !st && s.total < lim) begin
            n.total = s.total + 1;
            if (n.total % 60 == 0) n.carry = 1;
            if (n.total == lim) begin
                n.full = 1;
                n.run  = 0;
            end
        end
        if (l) n.lap = !s.lap;
        if (l && !s.lap) n.disp = s.total;
        else if (!n.lap) n.disp = n.total;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int k);
        chk($sformatf("d%0d_sec", k),   32'(sec_q[k]), 32'(m[k].disp % 60));
        chk($sformatf("d%0d_min", k),   32'(min_q[k]), 32'(m[k].disp / 60));
        chk($sformatf("d%0d_run", k),   32'(run[k]),   32'(m[k].run));
        chk($sformatf("d%0d_lap", k),   32'(lapa[k]),  32'(m[k].lap));
        chk($sformatf("d%0d_carry", k), 32'(carry[k]), 32'(m[k].carry));
        chk($sformatf("d%0d_full", k),  32'(full[k]),  32'(m[k].full));
    endtask

    task automatic cyc(input bit t, input bit st, input bit c, input bit l);
        @(negedge clk);
        tick = t; ss = st; clr = c; lap = l;
        @(posedge clk);
        for (int k = 0; k < 2; k++) m[k] = mstep(m[k], maxm(k), t, st, c, l);
        #1;
        chk_dut(0);
        chk_dut(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int ncar;

        // Power-on reset
        for (int k = 0; k < 2; k++) m[k] = mzero();
        repeat (2) @(posedge clk);
        #1;
        chk_dut(0);
        chk_dut(1);
        @(negedge clk);
        rst_n = 1'b1;

        // Start, 75 ticks, single carry on the 60th
        cyc(0, 1, 0, 0);
        ncar = 0;
        for (int i = 0; i < 75; i++) begin
            cyc(1, 0, 0, 0);
            if (carry[0]) begin
                ncar++;
                chk("carry_at_tick", 32'(i + 1), 32'd60);
            end
        end
        chk("t75_sec", 32'(sec_q[0]), 32'd15);
        chk("t75_min", 32'(min_q[0]), 32'd1);
        chk("t75_ncarry", 32'(ncar), 32'd1);

        // Stop gap
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(10);
        cyc(0, 1, 0, 0);
        chk("gap_run", 32'(run[0]), 32'd0);
        ticks(5);
        cyc(0, 1, 0, 0);
        ticks(3);
        chk("gap_sec", 32'(sec_q[0]), 32'd13);

        // Lap hold
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(20);
        cyc(0, 0, 0, 1);
        ticks(10);
        chk("lap_hold_sec", 32'(sec_q[0]), 32'd20);
        chk("lap_hold_act", 32'(lapa[0]), 32'd1);
        cyc(0, 0, 0, 1);
        chk("lap_rel_sec", 32'(sec_q[0]), 32'd30);
        // lap coincident with tick captures pre-tick count
        cyc(1, 0, 0, 1);
        chk("lap_tick_sec", 32'(sec_q[0]), 32'd30);

        // Saturation (instance with MAX_MIN=2)
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(200);
        chk("sat_sec", 32'(sec_q[1]), 32'd59);
        chk("sat_min", 32'(min_q[1]), 32'd2);
        chk("sat_full", 32'(full[1]), 32'd1);
        chk("sat_run", 32'(run[1]), 32'd0);
        cyc(0, 1, 0, 0);
        chk("sat_ss_ignored", 32'(run[1]), 32'd0);
        cyc(0, 0, 1, 0);
        chk("sat_clr_full", 32'(full[1]), 32'd0);

        // start_stop+tick from STOPPED, then clear+tick
        cyc(1, 1, 0, 0);
        chk("sstick_run", 32'(run[0]), 32'd1);
        chk("sstick_sec", 32'(sec_q[0]), 32'd0);
        ticks(5);
        cyc(1, 0, 1, 0);
        chk("clrtick_sec", 32'(sec_q[0]), 32'd0);
        chk("clrtick_run", 32'(run[0]), 32'd0);

        // Asynchronous reset mid-count at 01:07
        cyc(0, 1, 0, 0);
        ticks(67);
        chk("pre_rst_min", 32'(min_q[0]), 32'd1);
        @(posedge clk);
        #3;
        tick = 0; ss = 0; clr = 0; lap = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) m[k] = mzero();
        #1;
        chk_dut(0);
        chk_dut(1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 0, 0);
        ticks(1);
        chk("post_rst_sec", 32'(sec_q[0]), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 6,
                $urandom_range(0, 99) < 3,
                $urandom_range(0, 999) < 4,
                $urandom_range(0, 99) < 4);
        end
        @(negedge clk);
        tick = 0; ss = 0; clr = 0; lap = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
